// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the receive FSM state encoding and the default line timing and word
// size, so that a future transmit framer can use the same values.
package uart_pkg;

  localparam int unsigned DEF_CLKS_PER_BIT = 16;
  localparam int unsigned DEF_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  // Width of a counter that must hold values 0..n-1. Never less than 1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer for the UART receiver.
// Free-running counter over 0..CLKS_PER_BIT-1 that the owner can force back
// to zero. It is used both to find the middle of the start bit and to step
// from one bit centre to the next.
//   CLK       : system clock, rising edge
//   RST_N     : synchronous active-low reset
//   CLR       : force the counter to 0 on the next edge
//   HALF_TICK : counter == CLKS_PER_BIT/2 - 1
//   FULL_TICK : counter == CLKS_PER_BIT - 1
// CLKS_PER_BIT must be even and at least 4.
import uart_pkg::*;

module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic CLR,
  output logic HALF_TICK,
  output logic FULL_TICK
);

  localparam int unsigned CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (!RST_N || CLR)       cnt <= '0;
    else if (cnt == FULL_M1) cnt <= '0;
    else                     cnt <= cnt + CW'(1);
  end

  assign HALF_TICK = (cnt == HALF_M1);
  assign FULL_TICK = (cnt == FULL_M1);

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer.
// Recovers start / DATA_BITS data (LSB first) / one stop bit frames from an
// already synchronised serial line by sampling once at the middle of each bit.
//   CLK        : system clock, rising edge
//   RST_N      : synchronous active-low reset
//   EN         : receive enable, only looked at while idle
//   RX_IN      : serial line, idle high
//   DATA_OUT   : last correctly framed word, held between frames
//   DATA_VALID : one-cycle pulse when DATA_OUT is updated
//   FRAME_ERR  : one-cycle pulse when the stop bit is sampled low
//   BUSY       : high in any state other than idle
import uart_pkg::*;

module uart_rx_deframer #(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 EN,
  input  logic                 RX_IN,
  output logic [DATA_BITS-1:0] DATA_OUT,
  output logic                 DATA_VALID,
  output logic                 FRAME_ERR,
  output logic                 BUSY
);

  localparam int unsigned BW = cnt_w(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  rx_state_e state, state_d;

  logic                 half_tick, full_tick;
  logic                 tmr_clr;
  logic                 shift_en, idx_clr;
  logic                 valid_d, ferr_d;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tmr (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .CLR       (tmr_clr),
    .HALF_TICK (half_tick),
    .FULL_TICK (full_tick)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      bit_idx    <= '0;
      shreg      <= '0;
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      state      <= state_d;
      DATA_VALID <= valid_d;
      FRAME_ERR  <= ferr_d;
      if (idx_clr)       bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + BW'(1);
      // New bit enters at the top; after DATA_BITS shifts the first data
      // bit has walked down to bit 0.
      if (shift_en) shreg <= {RX_IN, shreg[DATA_BITS-1:1]};
      if (valid_d)  DATA_OUT <= shreg;
    end
  end

  always_comb begin
    state_d  = state;
    tmr_clr  = 1'b0;
    shift_en = 1'b0;
    idx_clr  = 1'b0;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    case (state)
      ST_IDLE: begin
        // Timer held at zero so it reads 0 on the cycle after the start edge.
        tmr_clr = 1'b1;
        idx_clr = 1'b1;
        if (EN && !RX_IN) state_d = ST_START;
      end
      ST_START: begin
        if (half_tick) begin
          // Restarting the timer here puts every later FULL_TICK on a bit centre.
          tmr_clr = 1'b1;
          if (!RX_IN) begin
            state_d = ST_DATA;
            idx_clr = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (full_tick) begin
          shift_en = 1'b1;
          if (bit_idx == LAST_BIT) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (full_tick) begin
          if (RX_IN) begin
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // Wait out a held-low line so it cannot be read as new start bits.
        tmr_clr = 1'b1;
        if (RX_IN) state_d = ST_IDLE;
      end
      default: begin
        tmr_clr = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign BUSY = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at CLKS_PER_BIT=16, DATA_BITS=8.
// Frames are driven 1ns after a rising edge; a negedge monitor records
// strobe counts, the cycle each strobe appeared and the captured word.
module tb_uart_rx_deframer;

  localparam int C  = 16;
  localparam int DB = 8;

  logic          CLK = 1'b0;
  logic          RST_N, EN, RX_IN;
  logic [DB-1:0] DATA_OUT;
  logic          DATA_VALID, FRAME_ERR, BUSY;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int dv_cnt = 0, fe_cnt = 0, busy_cnt = 0;
  int dv_cyc = -1, fe_cyc = -1;
  logic [DB-1:0] dv_dat = '0;
  int t0, ta, tb, first_cyc, b0;

  uart_rx_deframer #(.CLKS_PER_BIT(C), .DATA_BITS(DB)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .EN         (EN),
    .RX_IN      (RX_IN),
    .DATA_OUT   (DATA_OUT),
    .DATA_VALID (DATA_VALID),
    .FRAME_ERR  (FRAME_ERR),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (DATA_VALID === 1'b1) begin
      dv_cnt++;
      dv_cyc = cyc;
      dv_dat = DATA_OUT;
    end
    if (FRAME_ERR === 1'b1) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    if (BUSY === 1'b1) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Drives one full frame; EN drops at the start of data bit drop_bit
  // (pass -1 to leave EN alone). t0 is the edge that sees the start bit.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop,
                            input int drop_bit, output int t_start);
    RX_IN   = 1'b0;
    t_start = cyc + 1;
    tick(C);
    for (int i = 0; i < DB; i++) begin
      if (i == drop_bit) EN = 1'b0;
      RX_IN = d[i];
      tick(C);
    end
    RX_IN = stop;
    tick(C);
  endtask

  initial begin
    RST_N = 1'b0;
    EN    = 1'b0;
    RX_IN = 1'b1;
    tick(3);
    chk("rst_data",  32'(DATA_OUT),   32'h0);
    chk("rst_valid", 32'(DATA_VALID), 32'h0);
    chk("rst_ferr",  32'(FRAME_ERR),  32'h0);
    chk("rst_busy",  32'(BUSY),       32'h0);
    RST_N = 1'b1;
    tick(2);
    chk("idle_busy", 32'(BUSY), 32'h0);

    // Reset mid-frame: start bit plus three data bits, then a one-cycle reset.
    EN    = 1'b1;
    RX_IN = 1'b0;
    tick(C);
    for (int i = 0; i < 3; i++) begin
      RX_IN = 1'b1;
      tick(C);
    end
    chk("midrst_busy_before", 32'(BUSY), 32'h1);
    RST_N = 1'b0;
    tick(1);
    RST_N = 1'b1;
    RX_IN = 1'b1;
    chk("midrst_busy_after", 32'(BUSY), 32'h0);
    b0 = busy_cnt;
    tick(200);
    chk("midrst_data",     32'(DATA_OUT), 32'h0);
    chk("midrst_busy",     32'(BUSY),     32'h0);
    chk("midrst_busy_cnt", 32'(busy_cnt), 32'(b0));
    chk("midrst_dv_cnt",   32'(dv_cnt),   32'd0);
    chk("midrst_fe_cnt",   32'(fe_cnt),   32'd0);

    // Nominal 0xA5 frame.
    send_frame(8'hA5, 1'b1, -1, t0);
    chk("nom_dv_cnt", 32'(dv_cnt),   32'd1);
    chk("nom_dv_cyc", 32'(dv_cyc),   32'(t0 + 152));
    chk("nom_dv_dat", 32'(dv_dat),   32'hA5);
    chk("nom_data",   32'(DATA_OUT), 32'hA5);
    chk("nom_fe_cnt", 32'(fe_cnt),   32'd0);
    chk("nom_busy",   32'(BUSY),     32'h0);

    // False start: four low cycles only.
    RX_IN = 1'b0;
    t0    = cyc + 1;
    tick(4);
    RX_IN = 1'b1;
    tick(4);
    chk("fs_busy_t7", 32'(BUSY), 32'h1);
    tick(1);
    chk("fs_busy_t8", 32'(BUSY), 32'h0);
    tick(20);
    chk("fs_dv_cnt", 32'(dv_cnt), 32'd1);
    chk("fs_fe_cnt", 32'(fe_cnt), 32'd0);

    // Framing error: 0x3C with a low stop bit, then line held low.
    send_frame(8'h3C, 1'b0, -1, t0);
    tick(40);
    chk("fe_cnt",       32'(fe_cnt),   32'd1);
    chk("fe_cyc",       32'(fe_cyc),   32'(t0 + 152));
    chk("fe_data_hold", 32'(DATA_OUT), 32'hA5);
    chk("fe_dv_cnt",    32'(dv_cnt),   32'd1);
    chk("fe_busy_low",  32'(BUSY),     32'h1);
    RX_IN = 1'b1;
    tick(1);
    chk("fe_busy_rel", 32'(BUSY), 32'h0);
    tick(5);
    chk("fe_cnt_once", 32'(fe_cnt), 32'd1);

    // Back-to-back 0x00 then 0xFF.
    send_frame(8'h00, 1'b1, -1, ta);
    first_cyc = dv_cyc;
    chk("b2b_dv1_cnt", 32'(dv_cnt), 32'd2);
    chk("b2b_dv1_cyc", 32'(dv_cyc), 32'(ta + 152));
    chk("b2b_dv1_dat", 32'(dv_dat), 32'h00);
    send_frame(8'hFF, 1'b1, -1, tb);
    chk("b2b_dv2_cnt", 32'(dv_cnt),             32'd3);
    chk("b2b_gap",     32'(dv_cyc - first_cyc), 32'd160);
    chk("b2b_dv2_dat", 32'(dv_dat),             32'hFF);
    chk("b2b_data",    32'(DATA_OUT),           32'hFF);
    RX_IN = 1'b1;
    tick(2);

    // Enable gating: whole frame with EN low is ignored.
    EN = 1'b0;
    b0 = busy_cnt;
    send_frame(8'h55, 1'b1, -1, t0);
    tick(2);
    chk("en0_dv_cnt",   32'(dv_cnt),   32'd3);
    chk("en0_fe_cnt",   32'(fe_cnt),   32'd1);
    chk("en0_busy_cnt", 32'(busy_cnt), 32'(b0));
    chk("en0_data",     32'(DATA_OUT), 32'hFF);

    // EN dropped mid-frame: frame still completes.
    EN = 1'b1;
    send_frame(8'h55, 1'b1, 3, t0);
    chk("endrop_dv_cnt", 32'(dv_cnt),   32'd4);
    chk("endrop_dv_cyc", 32'(dv_cyc),   32'(t0 + 152));
    chk("endrop_data",   32'(DATA_OUT), 32'h55);
    chk("endrop_fe_cnt", 32'(fe_cnt),   32'd1);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
